exec_ctrl_alu: RTL and testbench

- Registered decode-and-execute slice of the 5-stage RV32I pipeline.
- Combines three functions:
  - main control decode from the opcode;
  - ALU-control decode from ALUOp, funct3 and instruction[30];
  - a 32-bit ALU with a zero flag.
- Takes the ID-stage instruction and operand values; presents control signals, ALU result and branch decision one cycle later for the EX/MEM boundary.

---
 rtl/exec_pkg.sv | 27 ++
 rtl/exec_ctrl_alu_alu32.sv | 36 +++
 rtl/exec_ctrl_alu.sv | 151 +++++++++++++++
 tb/tb_exec_ctrl_alu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the RV32I decode-and-execute slice: opcodes, ALUOp
// classes and the 4-bit ALU operation codes.
package exec_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

endpackage

// File: rtl/exec_ctrl_alu_alu32.sv
// Combinational 32-bit ALU: wrap-around add/sub, logic ops, shifts by b[4:0],
// signed/unsigned set-less-than. Unused operation codes yield zero.
module alu32
    import exec_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_SLTU: result = {31'b0, a < b};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/exec_ctrl_alu.sv
// Registered decode-and-execute slice: main control and ALU-control decode
// feed the ALU; everything is captured one cycle later for EX/MEM.
module exec_ctrl_alu
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] immediate,
    output logic            valid_out,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            alu_src,
    output logic            mem_to_reg,
    output logic [1:0]      alu_op,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            branch_taken,
    output logic [XLEN-1:0] store_data,
    output logic            illegal
);

    // valid_in qualifies the instruction and operands each cycle; there is no
    // ready, so a new instruction is taken every cycle and flush wins over it.
    logic        reg_write_d, mem_read_d, mem_write_d, branch_d, alu_src_d;
    logic        mem_to_reg_d, illegal_d;
    logic [1:0]  alu_op_d;
    logic [3:0]  alu_ctrl_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [XLEN-1:0] alu_b, result_d;
    logic        zero_d, capture;

    assign opcode  = instruction[6:0];
    assign funct3  = instruction[14:12];
    assign capture = valid_in & ~flush;

    always_comb begin
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        branch_d     = 1'b0;
        alu_src_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_op_d     = ALUOP_ADD;
        illegal_d    = 1'b0;
        case (opcode)
            OP_R:      begin reg_write_d = 1'b1; alu_op_d = ALUOP_R; end
            OP_IMM:    begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op_d = ALUOP_I; end
            OP_LOAD:   begin
                reg_write_d  = 1'b1;
                mem_read_d   = 1'b1;
                alu_src_d    = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            OP_STORE:  begin mem_write_d = 1'b1; alu_src_d = 1'b1; end
            OP_BRANCH: begin branch_d = 1'b1; alu_op_d = ALUOP_SUB; end
            // An all-zero word is a deliberate bubble, not an illegal op.
            default:   illegal_d = (instruction != 32'b0);
        endcase
    end

    always_comb begin
        alu_ctrl_d = ALU_ADD;
        case (alu_op_d)
            ALUOP_ADD: alu_ctrl_d = ALU_ADD;
            ALUOP_SUB: alu_ctrl_d = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: alu_ctrl_d = (alu_op_d == ALUOP_R && instruction[30]) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctrl_d = ALU_SLL;
                    3'b010: alu_ctrl_d = ALU_SLT;
                    3'b011: alu_ctrl_d = ALU_SLTU;
                    3'b100: alu_ctrl_d = ALU_XOR;
                    3'b101: alu_ctrl_d = instruction[30] ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl_d = ALU_OR;
                    default: alu_ctrl_d = ALU_AND;
                endcase
            end
        endcase
    end

    assign alu_b = alu_src_d ? immediate : rs2_data;

    alu32 u_alu (
        .a        (rs1_data),
        .b        (alu_b),
        .alu_ctrl (alu_ctrl_d),
        .result   (result_d),
        .zero     (zero_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            reg_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            branch       <= 1'b0;
            alu_src      <= 1'b0;
            mem_to_reg   <= 1'b0;
            alu_op       <= '0;
            alu_ctrl     <= '0;
            alu_result   <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            store_data   <= '0;
            illegal      <= 1'b0;
        end else if (capture) begin
            valid_out    <= 1'b1;
            reg_write    <= reg_write_d;
            mem_read     <= mem_read_d;
            mem_write    <= mem_write_d;
            branch       <= branch_d;
            alu_src      <= alu_src_d;
            mem_to_reg   <= mem_to_reg_d;
            alu_op       <= alu_op_d;
            alu_ctrl     <= alu_ctrl_d;
            alu_result   <= result_d;
            zero         <= zero_d;
            branch_taken <= branch_d & zero_d;
            store_data   <= rs2_data;
            illegal      <= illegal_d;
        end else begin
            valid_out    <= 1'b0;
            reg_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            branch       <= 1'b0;
            alu_src      <= 1'b0;
            mem_to_reg   <= 1'b0;
            alu_op       <= '0;
            alu_ctrl     <= '0;
            alu_result   <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            store_data   <= '0;
            illegal      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_ctrl_alu.sv
// Directed, table-driven bench for exec_ctrl_alu with hand-computed expected
// outputs, plus a hand-written asynchronous reset sequence.
module tb_exec_ctrl_alu;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        as;
        logic        m2r;
        logic [1:0]  op;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
        logic        taken;
        logic [31:0] sd;
        logic        ill;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        vin;
        logic        fl;
        out_t        exp;
    } vec_t;

    logic        clk, rst, valid_in, flush;
    logic [31:0] instruction, rs1_data, rs2_data, immediate;
    logic        valid_out, reg_write, mem_read, mem_write, branch, alu_src, mem_to_reg;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result, store_data;
    logic        zero, branch_taken, illegal;
    out_t        act;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t vecs[$];

    exec_ctrl_alu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
        .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .immediate(immediate), .valid_out(valid_out), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero),
        .branch_taken(branch_taken), .store_data(store_data), .illegal(illegal)
    );

    assign act = {valid_out, reg_write, mem_read, mem_write, branch, alu_src,
                  mem_to_reg, alu_op, alu_ctrl, alu_result, zero, branch_taken,
                  store_data, illegal};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t ex(logic v, logic rw, logic mr, logic mw, logic br,
                                logic as, logic m2r, logic [1:0] op, logic [3:0] ctrl,
                                logic [31:0] res, logic z, logic t, logic [31:0] sd,
                                logic ill);
        out_t o;
        o = {v, rw, mr, mw, br, as, m2r, op, ctrl, res, z, t, sd, ill};
        return o;
    endfunction

    task automatic add_vec(string n, logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                           logic [31:0] im, logic vi, logic fl, out_t e);
        vec_t v;
        v.name = n; v.instr = ins; v.rs1 = a; v.rs2 = b; v.imm = im;
        v.vin = vi; v.fl = fl; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(string n, out_t e);
        total_cnt++;
        if (act === e) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, act, e);
    endtask

    task automatic drive(logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                         logic [31:0] im, logic vi, logic fl);
        instruction = ins; rs1_data = a; rs2_data = b; immediate = im;
        valid_in = vi; flush = fl;
    endtask

    out_t zeros;
    out_t addi_exp;

    initial begin
        zeros = '0;
        addi_exp = ex(1,1,0,0,0,1,0,2'b11,4'b0010,32'd10,0,0,32'd0,0);

        //         name       instr         rs1           rs2           imm          vi fl
        add_vec("addi",  32'h00A00093, 32'd0,        32'd0,        32'd10,      1, 0, addi_exp);
        add_vec("add",   32'h002081B3, 32'd3,        32'd7,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b0010,32'd10,0,0,32'd7,0));
        add_vec("sub",   32'h40208233, 32'd7,        32'd3,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b0110,32'd4,0,0,32'd3,0));
        add_vec("and",   32'h0020F1B3, 32'd7,        32'd3,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b0000,32'd3,0,0,32'd3,0));
        add_vec("or",    32'h0020E1B3, 32'd4,        32'd3,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b0001,32'd7,0,0,32'd3,0));
        add_vec("sll",   32'h002091B3, 32'd7,        32'd3,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b0100,32'd56,0,0,32'd3,0));
        add_vec("sra",   32'h4020D1B3, 32'h80000000, 32'd4,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b1000,32'hF8000000,0,0,32'd4,0));
        add_vec("srl",   32'h0020D1B3, 32'h80000000, 32'd4,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b0101,32'h08000000,0,0,32'd4,0));
        add_vec("slt",   32'h0020A1B3, 32'hFFFFFFFF, 32'd1,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b0111,32'd1,0,0,32'd1,0));
        add_vec("sltu",  32'h0020B1B3, 32'hFFFFFFFF, 32'd1,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b1001,32'd0,1,0,32'd1,0));
        add_vec("xor",   32'h0020C1B3, 32'd5,        32'd3,        32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b0011,32'd6,0,0,32'd3,0));
        add_vec("add_wrap", 32'h002081B3, 32'hFFFFFFFF, 32'd1,     32'd0,       1, 0, ex(1,1,0,0,0,0,0,2'b10,4'b0010,32'd0,1,0,32'd1,0));
        add_vec("addi_neg", 32'hFFF00093, 32'd5,     32'd9,        32'hFFFFFFFF,1, 0, ex(1,1,0,0,0,1,0,2'b11,4'b0010,32'd4,0,0,32'd9,0));
        add_vec("srai",  32'h4041D093, 32'h80000000, 32'd0,        32'h00000404,1, 0, ex(1,1,0,0,0,1,0,2'b11,4'b1000,32'hF8000000,0,0,32'd0,0));
        add_vec("beq_eq",32'h00208063, 32'd5,        32'd5,        32'd0,       1, 0, ex(1,0,0,0,1,0,0,2'b01,4'b0110,32'd0,1,1,32'd5,0));
        add_vec("beq_ne",32'h00208063, 32'd5,        32'd6,        32'd0,       1, 0, ex(1,0,0,0,1,0,0,2'b01,4'b0110,32'hFFFFFFFF,0,0,32'd6,0));
        add_vec("lw",    32'h00812083, 32'h100,      32'h55,       32'd8,       1, 0, ex(1,1,1,0,0,1,1,2'b00,4'b0010,32'h108,0,0,32'h55,0));
        add_vec("sw",    32'h00112423, 32'h200,      32'hDEADBEEF, 32'd8,       1, 0, ex(1,0,0,1,0,1,0,2'b00,4'b0010,32'h208,0,0,32'hDEADBEEF,0));
        add_vec("flush", 32'h002081B3, 32'd3,        32'd7,        32'd0,       1, 1, zeros);
        add_vec("novalid", 32'h002081B3, 32'd3,      32'd7,        32'd0,       0, 0, zeros);
        add_vec("flush_novalid", 32'h0000007F, 32'd3, 32'd7,       32'd0,       0, 1, zeros);
        add_vec("illegal", 32'h0000007F, 32'd0,      32'd0,        32'd0,       1, 0, ex(1,0,0,0,0,0,0,2'b00,4'b0010,32'd0,1,0,32'd0,1));
        add_vec("zero_instr", 32'h00000000, 32'd3,   32'd4,        32'd0,       1, 0, ex(1,0,0,0,0,0,0,2'b00,4'b0010,32'd7,0,0,32'd4,0));

        rst = 1'b1;
        drive(32'h002081B3, 32'd3, 32'd7, 32'd0, 1, 0);
        #1 check("reset_async", zeros);
        @(posedge clk); #1 check("reset_held", zeros);
        @(negedge clk); rst = 1'b0;

        // driver: apply at negedge, compare just after the capturing edge
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].vin, vecs[i].fl);
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp);
        end

        // reset pulsed mid-cycle clears outputs before the next edge
        @(negedge clk);
        drive(32'h00A00093, 32'd0, 32'd0, 32'd10, 1, 0);
        @(posedge clk); #1 check("pre_reset_addi", addi_exp);
        #2 rst = 1'b1;
        #1 check("midcycle_reset", zeros);
        @(posedge clk); #1 check("reset_over_edge", zeros);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1 check("post_reset_addi", addi_exp);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
